// File: rtl/sram_frame_reader.sv
// sram_frame_reader: reads a packed framebuffer out of a synchronous SRAM,
// one 32-bit word at a time, and streams its four pixels little-endian
// over a valid/ready byte interface.
module sram_frame_reader #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int PIX_W     = 8,
    parameter int NUM_WORDS = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_last,
    input  logic              pix_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_t                  state_q, state_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [3:0][PIX_W-1:0]   word_q, word_d;
    logic [1:0]              idx_q, idx_d;
    logic [1:0]              idx_next;
    logic                    pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]        pix_data_q, pix_data_d;
    logic                    pix_last_q, pix_last_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Register every output and the sequencer state; reset returns to an idle, silent interface.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            word_q      <= '0;
            idx_q       <= 2'd0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_last_q  <= pix_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic; abort overrides every transition outside IDLE.
    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        word_d      = word_q;
        idx_d       = idx_q;
        idx_next    = idx_q + 2'd1;
        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_last_d  = pix_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_READ;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                    busy_d    = 1'b1;
                end
            end
            S_READ: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                word_d      = rd_data;
                idx_d       = 2'd0;
                pix_valid_d = 1'b1;
                pix_data_d  = rd_data[PIX_W-1:0];
                pix_last_d  = 1'b0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (pix_valid_q && pix_ready) begin
                    if (idx_q == 2'd3) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        if (rd_addr_q == LAST_ADDR) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                            rd_en_d   = 1'b1;
                            state_d   = S_READ;
                        end
                    end else begin
                        idx_d      = idx_next;
                        pix_data_d = word_q[idx_next];
                        pix_last_d = (idx_next == 2'd3) && (rd_addr_q == LAST_ADDR);
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            rd_en_d     = 1'b0;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
    assign pix_last  = pix_last_q;

endmodule

// File: doc/sram_frame_reader.md
Name: sram_frame_reader

Overview:
- Read-side sequencer for the 32-bit packed framebuffer SRAM (4 x 8-bit pixels per word, 256x256 frame = 16384 words).
- On start, it walks word addresses 0..NUM_WORDS-1 on the SRAM synchronous read port (1-cycle latency).
- Unpacks each word into 4 bytes and streams them out on a valid/ready byte interface toward the UART TX path.
- It is the reader counterpart of the FIFO->SRAM writer.

Parameters:
- ADDR_W, 14, SRAM word-address width.
- DATA_W, 32, SRAM word width; must equal 4*PIX_W.
- PIX_W, 8, pixel/byte width on the output stream.
- NUM_WORDS, 2**ADDR_W, words per frame; legal range 1..2**ADDR_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin frame readout; sampled only in IDLE.
- abort  in  1  cancel readout; return to IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last byte handshake.
- rd_en  out  1  SRAM read enable.
- rd_addr  out  ADDR_W  SRAM read word address.
- rd_data  in  DATA_W  SRAM read data, valid the cycle after rd_en.
- pix_valid  out  1  output byte valid.
- pix_data  out  PIX_W  output byte.
- pix_last  out  1  marks the final byte of the frame (qualified by pix_valid).
- pix_ready  in  1  downstream accepts the byte.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge): state=IDLE; busy, done, rd_en, pix_valid, pix_last = 0; rd_addr = 0; pix_data = 0; byte index = 0.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE:
  - start=1 at edge E0 -> READ, with rd_en=1 and rd_addr=0 during the next cycle, busy=1.
  - start in any other state is ignored.
- READ: rd_en high for exactly one cycle -> WAIT; rd_en drops to 0.
- WAIT:
  - rd_data is valid this cycle; at the edge, capture it into the word register and set byte index = 0.
  - -> SEND with pix_valid=1 and pix_data=rd_data[7:0].
- SEND:
  - pix_data = word[8*idx +: 8], little-endian: byte 0 = bits [7:0] goes out first.
  - On pix_valid && pix_ready, idx increments; pix_data and pix_valid are held stable while pix_ready=0.
  - Handshake on idx=3 with rd_addr < NUM_WORDS-1: rd_addr increments, rd_en=1 -> READ. pix_valid=0 for 2 cycles (READ, WAIT) before the next word.
  - Handshake on idx=3 with rd_addr = NUM_WORDS-1: pix_valid=0 -> DONE.
- pix_last = 1 only while presenting idx=3 of word NUM_WORDS-1.
- DONE: done=1 for one cycle, busy=0 at the following edge -> IDLE; rd_addr is held at its last value.
- Timing with pix_ready tied high:
  - First pix_valid rises 3 edges after E0.
  - Steady state is 6 cycles per word (4 valid, 2 gap).
  - A frame completes in 6*NUM_WORDS+1 cycles from E0 to the done pulse.
- abort=1 in any non-IDLE state:
  - Next state IDLE; rd_en, pix_valid, pix_last, busy = 0; done is NOT pulsed.
  - abort has priority over every other transition; it is a no-op in IDLE.
  - abort and start in the same IDLE cycle: start wins.
- rst_n=0 mid-frame: same values as reset, no partial byte emitted afterward.
- No read is ever issued while a byte is pending. Exactly NUM_WORDS reads and 4*NUM_WORDS byte handshakes per completed frame.
- rd_addr never exceeds NUM_WORDS-1 and never wraps.

Test Plan:
- ADDR_W=2, NUM_WORDS=4, SRAM model preloaded 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; pix_ready=1; pulse start.
  -> Bytes 0x00..0x0F in order, pix_last only on 0x0F.
  -> rd_en pulses at addr 0,1,2,3.
  -> done pulses once, 25 cycles after start edge; busy low after.
- Same frame with pix_ready toggled pseudo-randomly (50%).
  -> Identical byte sequence.
  -> pix_data/pix_valid stable during every ready=0 stall.
  -> Exactly 16 handshakes and 4 rd_en pulses.
- pix_ready=0 held 10 cycles on byte 0x05.
  -> pix_data=0x05 and pix_valid=1 throughout the stall; no rd_en.
  -> Resumes with 0x06 after ready rises.
- abort asserted during SEND of word 2, idx=1.
  -> Next cycle state IDLE, pix_valid=0, busy=0, no done.
  -> A new start replays from 0x00, rd_addr=0.
- rst_n=0 for one edge mid-WAIT, then start.
  -> All outputs at reset values, no stray pix_valid.
  -> Full frame 0x00..0x0F delivered after start.
- start re-pulsed while busy; NUM_WORDS=1.
  -> Repeated start ignored.
  -> NUM_WORDS=1 frame emits 4 bytes, pix_last on the 4th, done 7 cycles after start.
